// File: rtl/ws281x_pkg.sv
// Shared types and elaboration-time helpers for the WS281x chain driver.
package ws281x_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, LATCH} state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Floor conversion, clamped so that no phase is ever zero cycles long.
    function automatic int ns_to_cycles(input int t_ns, input int fclk);
        int c;
        c = (t_ns * fclk) / 1000;
        return (c < 1) ? 1 : c;
    endfunction

    function automatic logic [7:0] scale8(input logic [7:0] ch, input logic [7:0] bright);
        logic [15:0] prod;
        prod = {8'd0, ch} * ({8'd0, bright} + 16'd1);
        return prod[15:8];
    endfunction

endpackage

// File: rtl/ws281x_bit_encoder.sv
// One NRZ bit: CxH cycles high then CxL cycles low; bit_done marks the last low cycle
// so the next start can follow back-to-back without a gap.
module ws281x_bit_encoder #(
    parameter int C0H   = 40,
    parameter int C1H   = 80,
    parameter int C0L   = 85,
    parameter int C1L   = 45,
    parameter int CNT_W = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic bit_val_i,
    output logic data_o,
    output logic high_done_o,
    output logic bit_done_o
);

    localparam logic [CNT_W-1:0] C0H_M1 = CNT_W'(C0H - 1);
    localparam logic [CNT_W-1:0] C1H_M1 = CNT_W'(C1H - 1);
    localparam logic [CNT_W-1:0] C0L_M1 = CNT_W'(C0L - 1);
    localparam logic [CNT_W-1:0] C1L_M1 = CNT_W'(C1L - 1);

    logic             data_q, data_d;
    logic             run_q, run_d;
    logic             val_q, val_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        data_d = data_q;
        run_d  = run_q;
        val_d  = val_q;
        cnt_d  = cnt_q;
        if (start_i) begin
            data_d = 1'b1;
            run_d  = 1'b1;
            val_d  = bit_val_i;
            cnt_d  = bit_val_i ? C1H_M1 : C0H_M1;
        end else if (run_q) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else if (data_q) begin
                data_d = 1'b0;
                cnt_d  = val_q ? C1L_M1 : C0L_M1;
            end else begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking assignments so all state updates see pre-edge values.
        if (rst_i) begin
            data_q <= 1'b0;
            run_q  <= 1'b0;
            val_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            run_q  <= run_d;
            val_q  <= val_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_o      = data_q;
    assign high_done_o = run_q &  data_q & (cnt_q == '0);
    assign bit_done_o  = run_q & ~data_q & (cnt_q == '0);

endmodule

// File: rtl/ws281x_chain.sv
// WS2812B/SK6812 chain driver: pixel memory, brightness scaling, frame sequencing and
// the post-frame latch period. Bit timing lives in ws281x_bit_encoder.
module ws281x_chain
    import ws281x_pkg::*;
#(
    parameter int          FCLK         = 100,
    parameter int          NB_LEDS      = 8,
    parameter int          BPP          = 24,
    parameter logic [31:0] START_COLOR  = 32'h00101010,
    parameter int          T0H          = 400,
    parameter int          T1H          = 800,
    parameter int          T0L          = 850,
    parameter int          T1L          = 450,
    parameter int          TRST         = 100000,
    parameter int          AUTO_REFRESH = 0,
    localparam int         AW           = (NB_LEDS > 1) ? $clog2(NB_LEDS) : 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           wr_en_i,
    input  logic [AW-1:0]  wr_addr_i,
    input  logic [BPP-1:0] wr_data_i,
    input  logic [7:0]     bright_i,
    input  logic           frame_req_i,
    output logic           busy_o,
    output logic           frame_done_o,
    output logic           data_o
);

    if (BPP != 24 && BPP != 32) begin : g_bad_bpp
        $error("ws281x_chain: BPP must be 24 or 32");
    end

    localparam int C0H   = ns_to_cycles(T0H, FCLK);
    localparam int C1H   = ns_to_cycles(T1H, FCLK);
    localparam int C0L   = ns_to_cycles(T0L, FCLK);
    localparam int C1L   = ns_to_cycles(T1L, FCLK);
    localparam int CRST  = ns_to_cycles(TRST, FCLK);
    localparam int CNT_W = $clog2(max_int(CRST, max_int(C0H + C0L, C1H + C1L))) + 1;
    localparam int NCH   = BPP / 8;
    localparam int BIT_W = $clog2(BPP);

    localparam logic [CNT_W-1:0] CRST_M1   = CNT_W'(CRST - 1);
    localparam logic [AW-1:0]    LAST_LED  = AW'(NB_LEDS - 1);
    localparam logic [AW:0]      NB_LEDS_W = (AW + 1)'(NB_LEDS);

    // NOTE: pixel memory has no reset; it powers up with START_COLOR and survives rst.
    logic [BPP-1:0] mem_q [NB_LEDS] = '{default: START_COLOR[BPP-1:0]};

    state_t           state_q, state_d;
    logic [AW-1:0]    led_q, led_d, load_addr;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [BPP-1:0]   shift_q, shift_d, rd_word, scaled;
    logic [7:0]       bright_q, bright_d;
    logic [CNT_W-1:0] latch_q, latch_d;
    logic             pending_q, pending_d;
    logic             after_q, after_d;
    logic             frame_done_q, frame_done_d;
    logic             start, start_val, do_load, high_done, bit_done;

    always_ff @(posedge clk_i) begin
        if (wr_en_i && ({1'b0, wr_addr_i} < NB_LEDS_W)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // The LOW-state load fetches the next LED during the previous pixel's final low cycle.
    assign load_addr = (state_q == LOAD) ? led_q : led_q + AW'(1);
    assign rd_word   = mem_q[load_addr];

    always_comb begin
        scaled = '0;
        for (int c = 0; c < NCH; c++) begin
            scaled[c*8 +: 8] = scale8(rd_word[c*8 +: 8], bright_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        led_d        = led_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        bright_d     = bright_q;
        latch_d      = latch_q;
        pending_d    = pending_q;
        after_d      = after_q;
        frame_done_d = 1'b0;
        start        = 1'b0;
        start_val    = 1'b0;
        do_load      = 1'b0;

        if (frame_req_i && state_q != IDLE) pending_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (frame_req_i || pending_q || (AUTO_REFRESH != 0)) begin
                    state_d   = LOAD;
                    led_d     = '0;
                    bright_d  = bright_i;
                    pending_d = 1'b0;
                end
            end
            LOAD: begin
                do_load = 1'b1;
                state_d = HIGH;
            end
            HIGH: begin
                if (high_done) state_d = LOW;
            end
            LOW: begin
                if (bit_done) begin
                    if (bit_q != '0) begin
                        start     = 1'b1;
                        start_val = shift_q[BPP-2];
                        shift_d   = shift_q << 1;
                        bit_d     = bit_q - BIT_W'(1);
                        state_d   = HIGH;
                    end else if (led_q == LAST_LED) begin
                        state_d = LATCH;
                        latch_d = CRST_M1;
                        after_d = 1'b1;
                    end else begin
                        do_load = 1'b1;
                        led_d   = led_q + AW'(1);
                        state_d = HIGH;
                    end
                end
            end
            LATCH: begin
                if (latch_q == '0) begin
                    state_d      = IDLE;
                    frame_done_d = after_q;
                    after_d      = 1'b0;
                end else begin
                    latch_d = latch_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_load) begin
            start     = 1'b1;
            start_val = scaled[BPP-1];
            shift_d   = scaled;
            bit_d     = BIT_W'(BPP - 1);
        end
    end

    // Reset lands in LATCH so the line is held low for a full latch period after power-up.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= LATCH;
            led_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            bright_q     <= '0;
            latch_q      <= CRST_M1;
            pending_q    <= 1'b0;
            after_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            led_q        <= led_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            bright_q     <= bright_d;
            latch_q      <= latch_d;
            pending_q    <= pending_d;
            after_q      <= after_d;
            frame_done_q <= frame_done_d;
        end
    end

    ws281x_bit_encoder #(
        .C0H   (C0H),
        .C1H   (C1H),
        .C0L   (C0L),
        .C1L   (C1L),
        .CNT_W (CNT_W)
    ) u_enc (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start),
        .bit_val_i   (start_val),
        .data_o      (data_o),
        .high_done_o (high_done),
        .bit_done_o  (bit_done)
    );

    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_ws281x_chain.sv
// Scoreboard bench: a 24-bit and a 32-bit chain share stimulus; a line monitor measures
// every bit's high/low run and compares it against hand-computed expected bit streams.
module tb_ws281x_chain;

    localparam int C0H  = 40;
    localparam int C1H  = 80;
    localparam int C0L  = 85;
    localparam int C1L  = 45;
    localparam int CRST = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [0:0]  wr_addr = '0;
    logic [23:0] wr_data24 = '0;
    logic [31:0] wr_data32 = '0;
    logic [7:0]  bright = 8'd255;
    logic        frame_req = 1'b0;
    logic        busy24, fd24, data24;
    logic        busy32, fd32, data32;

    always #5 clk = ~clk;

    ws281x_chain #(
        .FCLK(100), .NB_LEDS(2), .BPP(24), .START_COLOR(32'h00101010),
        .T0H(400), .T1H(800), .T0L(850), .T1L(450), .TRST(2000), .AUTO_REFRESH(0)
    ) dut24 (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data24), .bright_i(bright), .frame_req_i(frame_req),
        .busy_o(busy24), .frame_done_o(fd24), .data_o(data24)
    );

    ws281x_chain #(
        .FCLK(100), .NB_LEDS(2), .BPP(32), .START_COLOR(32'h00101010),
        .T0H(400), .T1H(800), .T0L(850), .T1L(450), .TRST(2000), .AUTO_REFRESH(0)
    ) dut32 (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data32), .bright_i(bright), .frame_req_i(frame_req),
        .busy_o(busy32), .frame_done_o(fd32), .data_o(data32)
    );

    typedef struct packed {
        logic val;
        logic last;
    } exp_t;

    exp_t exp24_q[$];
    exp_t exp32_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   frames_exp = 0;
    int   fd_seen [2] = '{0, 0};
    int   mon_h [2] = '{0, 0};
    int   mon_l [2] = '{0, 0};

    task automatic check(input string name, input longint act, input longint req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    endtask

    task automatic push_word(input int id, input logic [31:0] w, input int nbits, input bit last_word);
        exp_t e;
        for (int i = nbits - 1; i >= 0; i--) begin
            e.val  = w[i];
            e.last = last_word && (i == 0);
            if (id == 0) exp24_q.push_back(e);
            else         exp32_q.push_back(e);
        end
    endtask

    task automatic push_frame(input logic [23:0] a24, input logic [23:0] b24,
                              input logic [31:0] a32, input logic [31:0] b32);
        push_word(0, {8'd0, a24}, 24, 1'b0);
        push_word(0, {8'd0, b24}, 24, 1'b1);
        push_word(1, a32, 32, 1'b0);
        push_word(1, b32, 32, 1'b1);
        frames_exp++;
    endtask

    task automatic finish_bit(input int id, input bit is_last);
        exp_t  e;
        string tag;
        tag = (id == 0) ? "dut24" : "dut32";
        if (id == 0) begin
            if (exp24_q.size() == 0) begin
                check({tag, " unexpected bit, queue size"}, exp24_q.size(), 1);
                return;
            end
            e = exp24_q.pop_front();
        end else begin
            if (exp32_q.size() == 0) begin
                check({tag, " unexpected bit, queue size"}, exp32_q.size(), 1);
                return;
            end
            e = exp32_q.pop_front();
        end
        check({tag, " bit high cycles"}, mon_h[id], e.val ? C1H : C0H);
        check({tag, " bit low cycles"}, mon_l[id], (e.val ? C1L : C0L) + (e.last ? CRST : 0));
        check({tag, " bit frame-end flag"}, is_last, e.last);
    endtask

    task automatic mon_step(input int id, input logic d, input logic fd);
        if (rst) begin
            mon_h[id] = 0;
            mon_l[id] = 0;
        end else if (d) begin
            if (mon_l[id] > 0) begin
                finish_bit(id, 1'b0);
                mon_h[id] = 0;
                mon_l[id] = 0;
            end
            mon_h[id]++;
        end else if (fd) begin
            fd_seen[id]++;
            if (mon_h[id] > 0) finish_bit(id, 1'b1);
            mon_h[id] = 0;
            mon_l[id] = 0;
        end else if (mon_h[id] > 0) begin
            mon_l[id]++;
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, data24, fd24);
        mon_step(1, data32, fd32);
    end

    task automatic pulse_req();
        @(posedge clk); #2 frame_req = 1'b1;
        @(posedge clk); #2 frame_req = 1'b0;
    endtask

    task automatic write_px(input logic [0:0] a, input logic [23:0] d24, input logic [31:0] d32);
        @(posedge clk); #2 wr_en = 1'b1; wr_addr = a; wr_data24 = d24; wr_data32 = d32;
        @(posedge clk); #2 wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy24 || busy32) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        check({name, " finished within budget"}, busy24 || busy32, 0);
    endtask

    task automatic check_latch(input string name);
        int n = 0;
        int hi = 0;
        while (n < 1000) begin
            @(negedge clk);
            if (!(busy24 && busy32)) break;
            if (data24 || data32) hi++;
            n++;
        end
        check({name, " busy cycles"}, n, CRST);
        check({name, " data high cycles"}, hi, 0);
        check({name, " busy24 dropped"}, busy24, 0);
        check({name, " busy32 dropped"}, busy32, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset values, then the power-up latch period.
        repeat (3) @(posedge clk);
        #1;
        check("reset busy24", busy24, 1);
        check("reset busy32", busy32, 1);
        check("reset data24", data24, 0);
        check("reset frame_done24", fd24, 0);
        @(posedge clk); #2 rst = 1'b0;
        check_latch("power-up latch");

        // Untouched memory holds START_COLOR; also the request-to-line latency.
        bright = 8'd255;
        push_frame(24'h101010, 24'h101010, 32'h00101010, 32'h00101010);
        pulse_req();
        @(negedge clk);
        check("latency n+1 data24", data24, 0);
        @(negedge clk);
        check("latency n+2 data24", data24, 1);
        check("latency n+2 data32", data32, 1);
        wait_idle("start color frame");

        write_px(1'b0, 24'h800000, 32'h000000FF);
        write_px(1'b1, 24'h000000, 32'h000000FF);
        push_frame(24'h800000, 24'h000000, 32'h000000FF, 32'h000000FF);
        pulse_req();
        wait_idle("basic frame");

        bright = 8'd127;
        write_px(1'b0, 24'hFF00FF, 32'hFF00FF80);
        write_px(1'b1, 24'h123456, 32'h000000FF);
        push_frame(24'h7F007F, 24'h091A2B, 32'h7F007F40, 32'h0000007F);
        pulse_req();
        wait_idle("bright 127 frame");

        // Mid-frame: LED1 rewrite, bright change, three collapsed requests.
        bright = 8'd255;
        push_frame(24'hFF00FF, 24'h00AA55, 32'hFF00FF80, 32'h01020304);
        push_frame(24'h000000, 24'h000000, 32'h00000000, 32'h00000000);
        pulse_req();
        repeat (10) @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            pulse_req();
            repeat (5) @(posedge clk);
        end
        write_px(1'b1, 24'h00AA55, 32'h01020304);
        @(posedge clk); #2 bright = 8'd0;
        n = 0;
        while (!fd24 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("pending: first frame_done24 seen", fd24, 1);
        @(negedge clk);
        check("pending: IDLE+1 data24", data24, 0);
        @(negedge clk);
        check("pending: IDLE+2 data24", data24, 1);
        wait_idle("pending frames");
        repeat (300) @(negedge clk);
        check("no third frame busy24", busy24, 0);
        check("no third frame busy32", busy32, 0);

        // Abort mid-HIGH with reset; memory must survive.
        bright = 8'd255;
        pulse_req();
        repeat (10) @(posedge clk);
        #1;
        check("pre-abort data24 high", data24, 1);
        #1 rst = 1'b1;
        #1;
        check("abort data24 low", data24, 0);
        check("abort data32 low", data32, 0);
        check("abort busy24", busy24, 1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        check_latch("post-abort latch");
        push_frame(24'hFF00FF, 24'h00AA55, 32'hFF00FF80, 32'h01020304);
        pulse_req();
        wait_idle("post-abort frame");

        repeat (10) @(negedge clk);
        check("dut24 leftover expected bits", exp24_q.size(), 0);
        check("dut32 leftover expected bits", exp32_q.size(), 0);
        check("dut24 frame_done count", fd_seen[0], frames_exp);
        check("dut32 frame_done count", fd_seen[1], frames_exp);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
